pool2d_engine: RTL and testbench



---
 rtl/pool_pkg.sv | 28 ++
 rtl/pool_window_acc.sv | 50 +++++
 rtl/pool2d_engine.sv | 161 ++++++++++++++++
 tb/tb_pool2d_engine.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and elaboration-time helpers for the 2D pooling engine.
package pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } pool_state_e;

    function automatic int pool_out_dim(input int in_dim, input int k, input int stride);
        return (in_dim - k) / stride + 1;
    endfunction

    // Average-mode sum needs headroom for K*K terms.
    function automatic int pool_sum_w(input int data_w, input int k);
        return data_w + 2 * $clog2(k);
    endfunction

    function automatic int pool_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_window_acc.sv
// Per-window accumulator: running max or running sum, with the pooled result
// presented combinationally alongside the last element of each window.
module pool_window_acc
    import pool_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int K      = 2,
    parameter bit AVG_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic                     i_first,
    input  logic                     i_last,
    input  pool_mode_e               i_mode,
    input  logic signed [DATA_W-1:0] i_elem,
    output logic signed [DATA_W-1:0] o_result,
    output logic                     o_result_valid
);

    localparam int SHIFT = 2 * $clog2(K);
    localparam int SUM_W = pool_sum_w(DATA_W, K);

    logic signed [SUM_W-1:0] r_acc;
    logic signed [SUM_W-1:0] w_elem;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_max;
    logic signed [SUM_W-1:0] w_next;
    logic                    w_avg;

    // The first element of a window seeds the accumulator, so max never sees 0.
    always_comb begin
        w_avg          = AVG_EN && (i_mode == POOL_AVG);
        w_elem         = SUM_W'(i_elem);
        w_sum          = (i_first ? SUM_W'(0) : r_acc) + w_elem;
        w_max          = (i_first || (w_elem > r_acc)) ? w_elem : r_acc;
        w_next         = w_avg ? w_sum : w_max;
        o_result       = w_avg ? DATA_W'(w_next >>> SHIFT) : DATA_W'(w_next);
        o_result_valid = i_valid && i_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_valid) begin
            r_acc <= w_next;
        end
    end

endmodule

// File: rtl/pool2d_engine.sv
// Parametrised 2D max/average pooling engine: walks c, oy, ox, ky, kx one
// element per cycle and writes each finished window into the flat output map.
module pool2d_engine
    import pool_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int IN_W     = 28,
    parameter int IN_H     = 28,
    parameter int K        = 2,
    parameter int STRIDE   = 2,
    parameter int CHANNELS = 1,
    parameter bit AVG_EN   = 1'b1,
    localparam int OUT_W   = pool_out_dim(IN_W, K, STRIDE),
    localparam int OUT_H   = pool_out_dim(IN_H, K, STRIDE),
    localparam int N_OUT   = CHANNELS * OUT_H * OUT_W
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  mode,
    input  logic [CHANNELS*IN_H*IN_W*DATA_W-1:0]  in_map,
    output logic [N_OUT*DATA_W-1:0]               out_map,
    output logic                                  busy,
    output logic                                  done
);

    localparam int N_IN = CHANNELS * IN_H * IN_W;
    localparam int CW   = pool_cnt_w(CHANNELS);
    localparam int YW   = pool_cnt_w(OUT_H);
    localparam int XW   = pool_cnt_w(OUT_W);
    localparam int KW   = pool_cnt_w(K);
    localparam int IW   = pool_cnt_w(N_IN);
    localparam int OW   = pool_cnt_w(N_OUT);

    if (STRIDE < 1) begin : g_bad_stride
        $error("pool2d_engine: STRIDE must be >= 1");
    end
    if (AVG_EN && ((K & (K - 1)) != 0)) begin : g_bad_avg_k
        $error("pool2d_engine: average mode needs K to be a power of two");
    end

    pool_state_e             r_state;
    pool_state_e             w_state_next;
    pool_mode_e              r_mode;
    logic [CW-1:0]           r_c;
    logic [YW-1:0]           r_oy;
    logic [XW-1:0]           r_ox;
    logic [KW-1:0]           r_ky;
    logic [KW-1:0]           r_kx;
    logic                    w_start_ok;
    logic                    w_busy;
    logic                    w_first;
    logic                    w_last_k;
    logic                    w_last_all;
    logic [IW-1:0]           w_idx;
    logic [OW-1:0]           w_oi;
    logic signed [DATA_W-1:0] w_elems [N_IN];
    logic signed [DATA_W-1:0] r_out   [N_OUT];
    logic signed [DATA_W-1:0] w_result;
    logic                    w_result_valid;

    genvar gi;
    for (gi = 0; gi < N_IN; gi++) begin : g_in
        assign w_elems[gi] = in_map[gi*DATA_W +: DATA_W];
    end
    for (gi = 0; gi < N_OUT; gi++) begin : g_out
        assign out_map[gi*DATA_W +: DATA_W] = r_out[gi];
    end

    always_comb begin
        w_start_ok = start && (r_state != ACCUM);
        w_busy     = (r_state == ACCUM);
        w_first    = (r_kx == '0) && (r_ky == '0);
        w_last_k   = (r_kx == KW'(K - 1)) && (r_ky == KW'(K - 1));
        w_last_all = w_last_k && (r_ox == XW'(OUT_W - 1)) && (r_oy == YW'(OUT_H - 1))
                     && (r_c == CW'(CHANNELS - 1));
        w_idx      = IW'((int'(r_c) * IN_H + int'(r_oy) * STRIDE + int'(r_ky)) * IN_W
                         + int'(r_ox) * STRIDE + int'(r_kx));
        w_oi       = OW'((int'(r_c) * OUT_H + int'(r_oy)) * OUT_W + int'(r_ox));
        busy       = w_busy;
        done       = (r_state == DONE);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = ACCUM;
            ACCUM:   if (w_last_all) w_state_next = DONE;
            DONE:    if (start) w_state_next = ACCUM;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_mode  <= POOL_MAX;
        end else begin
            r_state <= w_state_next;
            if (w_start_ok) r_mode <= pool_mode_e'(mode);
        end
    end

    // kx is the fastest index; each wrap carries into the next counter out.
    always_ff @(posedge clk) begin
        if (reset || w_start_ok) begin
            r_c  <= '0;
            r_oy <= '0;
            r_ox <= '0;
            r_ky <= '0;
            r_kx <= '0;
        end else if (w_busy) begin
            if (r_kx == KW'(K - 1)) begin
                r_kx <= '0;
                if (r_ky == KW'(K - 1)) begin
                    r_ky <= '0;
                    if (r_ox == XW'(OUT_W - 1)) begin
                        r_ox <= '0;
                        if (r_oy == YW'(OUT_H - 1)) begin
                            r_oy <= '0;
                            r_c  <= (r_c == CW'(CHANNELS - 1)) ? '0 : r_c + 1'b1;
                        end else begin
                            r_oy <= r_oy + 1'b1;
                        end
                    end else begin
                        r_ox <= r_ox + 1'b1;
                    end
                end else begin
                    r_ky <= r_ky + 1'b1;
                end
            end else begin
                r_kx <= r_kx + 1'b1;
            end
        end
    end

    pool_window_acc #(
        .DATA_W (DATA_W),
        .K      (K),
        .AVG_EN (AVG_EN)
    ) u_acc (
        .clk            (clk),
        .reset          (reset),
        .i_valid        (w_busy),
        .i_first        (w_first),
        .i_last         (w_last_k),
        .i_mode         (r_mode),
        .i_elem         (w_elems[w_idx]),
        .o_result       (w_result),
        .o_result_valid (w_result_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_OUT; i++) r_out[i] <= '0;
        end else if (w_result_valid) begin
            r_out[w_oi] <= w_result;
        end
    end

endmodule

// File: tb/tb_pool2d_engine.sv
// Scoreboard bench for pool2d_engine: a 4x4 K2/S2 instance and a 4x4 K3/S1
// two-channel instance, expected windows queued at stimulus time.
module tb_pool2d_engine;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              a_start, a_mode, a_busy, a_done;
    logic [16*DW-1:0]  a_in;
    logic [4*DW-1:0]   a_out;
    logic signed [DW-1:0] a_in_arr  [16];
    logic signed [DW-1:0] a_out_arr [4];

    logic              b_start, b_mode, b_busy, b_done;
    logic [32*DW-1:0]  b_in;
    logic [8*DW-1:0]   b_out;
    logic signed [DW-1:0] b_in_arr  [32];
    logic signed [DW-1:0] b_out_arr [8];

    int n_cmp = 0;
    int n_bad = 0;
    logic signed [DW-1:0] exp_q [$];

    genvar gi;
    for (gi = 0; gi < 16; gi++) begin : g_ain
        assign a_in[gi*DW +: DW] = a_in_arr[gi];
    end
    for (gi = 0; gi < 4; gi++) begin : g_aout
        assign a_out_arr[gi] = a_out[gi*DW +: DW];
    end
    for (gi = 0; gi < 32; gi++) begin : g_bin
        assign b_in[gi*DW +: DW] = b_in_arr[gi];
    end
    for (gi = 0; gi < 8; gi++) begin : g_bout
        assign b_out_arr[gi] = b_out[gi*DW +: DW];
    end

    pool2d_engine #(
        .DATA_W(DW), .IN_W(4), .IN_H(4), .K(2), .STRIDE(2), .CHANNELS(1), .AVG_EN(1'b1)
    ) u_a (
        .clk(clk), .reset(rst), .start(a_start), .mode(a_mode),
        .in_map(a_in), .out_map(a_out), .busy(a_busy), .done(a_done)
    );

    pool2d_engine #(
        .DATA_W(DW), .IN_W(4), .IN_H(4), .K(3), .STRIDE(1), .CHANNELS(2), .AVG_EN(1'b0)
    ) u_b (
        .clk(clk), .reset(rst), .start(b_start), .mode(b_mode),
        .in_map(b_in), .out_map(b_out), .busy(b_busy), .done(b_done)
    );

    // Reference pooling for the 4x4 K=2 S=2 instance; average floors toward -inf.
    function automatic logic signed [DW-1:0] model_a(input int oy, input int ox, input logic avg);
        longint s = 0;
        longint mx = 0;
        longint v;
        longint q;
        for (int ky = 0; ky < 2; ky++) begin
            for (int kx = 0; kx < 2; kx++) begin
                v = longint'(a_in_arr[(2*oy+ky)*4 + 2*ox + kx]);
                s += v;
                if ((ky == 0 && kx == 0) || v > mx) mx = v;
            end
        end
        if (avg) begin
            q = s / 4;
            if (s < 0 && (s % 4) != 0) q = q - 1;
            return DW'(q);
        end
        return DW'(mx);
    endfunction

    task automatic run_a(input logic m, input int pulse_at, output int cycles,
                         output int busy_cycles, output logic done0);
        @(negedge clk);
        a_mode  = m;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        done0 = a_done;
        cycles = 0;
        busy_cycles = 0;
        while (a_done !== 1'b1 && cycles < 200) begin
            if (a_busy === 1'b1) busy_cycles++;
            if (cycles == pulse_at) begin
                a_start = 1'b1;
                a_mode  = ~m;
            end
            @(posedge clk); #1;
            a_start = 1'b0;
            cycles++;
        end
        $display("run A mode=%0d: done after %0d cycles, busy %0d cycles", m, cycles, busy_cycles);
    endtask

    task automatic run_b(input logic m, output int cycles, output int busy_cycles);
        @(negedge clk);
        b_mode  = m;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        cycles = 0;
        busy_cycles = 0;
        while (b_done !== 1'b1 && cycles < 400) begin
            if (b_busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
            cycles++;
        end
        $display("run B mode=%0d: done after %0d cycles, busy %0d cycles", m, cycles, busy_cycles);
    endtask

    task automatic test_reset();
        logic signed [DW-1:0] e;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 4;
        if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_a_busy: got %b want 0", a_busy); end
        if (a_done !== 1'b0) begin n_bad++; $display("FAIL reset_a_done: got %b want 0", a_done); end
        if (b_busy !== 1'b0) begin n_bad++; $display("FAIL reset_b_busy: got %b want 0", b_busy); end
        if (b_done !== 1'b0) begin n_bad++; $display("FAIL reset_b_done: got %b want 0", b_done); end
        for (int i = 0; i < 12; i++) exp_q.push_back('0);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (a_out_arr[i] !== e) begin n_bad++; $display("FAIL reset_a_out[%0d]: got %0d want %0d", i, a_out_arr[i], e); end
        end
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (b_out_arr[i] !== e) begin n_bad++; $display("FAIL reset_b_out[%0d]: got %0d want %0d", i, b_out_arr[i], e); end
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset: checked idle outputs");
    endtask

    task automatic test_max();
        int cyc, bcyc;
        logic d0;
        logic signed [DW-1:0] e;
        for (int i = 0; i < 16; i++) a_in_arr[i] = DW'(i);
        exp_q.push_back(5); exp_q.push_back(7); exp_q.push_back(13); exp_q.push_back(15);
        run_a(1'b0, -1, cyc, bcyc, d0);
        n_cmp += 3;
        if (cyc != 16)  begin n_bad++; $display("FAIL max_latency: got %0d want 16", cyc); end
        if (bcyc != 16) begin n_bad++; $display("FAIL max_busy_cycles: got %0d want 16", bcyc); end
        if (a_busy !== 1'b0) begin n_bad++; $display("FAIL max_busy_at_done: got %b want 0", a_busy); end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (a_out_arr[i] !== e) begin n_bad++; $display("FAIL max_out[%0d]: got %0d want %0d", i, a_out_arr[i], e); end
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (a_done !== 1'b1) begin n_bad++; $display("FAIL max_done_held: got %b want 1", a_done); end
    endtask

    task automatic test_avg();
        int cyc, bcyc;
        logic d0;
        logic signed [DW-1:0] e;
        for (int i = 0; i < 16; i++) a_in_arr[i] = DW'(i);
        exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(10); exp_q.push_back(12);
        run_a(1'b1, -1, cyc, bcyc, d0);
        n_cmp++;
        if (cyc != 16) begin n_bad++; $display("FAIL avg_latency: got %0d want 16", cyc); end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (a_out_arr[i] !== e) begin n_bad++; $display("FAIL avg_out[%0d]: got %0d want %0d", i, a_out_arr[i], e); end
        end
        for (int i = 0; i < 16; i++) a_in_arr[i] = '0;
        a_in_arr[0] = -1; a_in_arr[1] = -2; a_in_arr[4] = -3; a_in_arr[5] = -4;
        a_in_arr[2] = 1;
        a_in_arr[8] = -1;
        a_in_arr[10] = 7; a_in_arr[11] = 7; a_in_arr[14] = 7; a_in_arr[15] = 7;
        exp_q.push_back(-3); exp_q.push_back(0); exp_q.push_back(-1); exp_q.push_back(7);
        run_a(1'b1, -1, cyc, bcyc, d0);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (a_out_arr[i] !== e) begin n_bad++; $display("FAIL avg_floor_out[%0d]: got %0d want %0d", i, a_out_arr[i], e); end
        end
    endtask

    task automatic test_neg_max();
        int cyc, bcyc;
        logic d0;
        logic signed [DW-1:0] e;
        a_in_arr[0] = -5;    a_in_arr[1] = -7;  a_in_arr[4] = -9;  a_in_arr[5] = -6;
        a_in_arr[2] = -100;  a_in_arr[3] = -3;  a_in_arr[6] = -50; a_in_arr[7] = 32'sh80000000;
        a_in_arr[8] = 4;     a_in_arr[9] = 4;   a_in_arr[12] = 4;  a_in_arr[13] = 4;
        a_in_arr[10] = 32'sh7fffffff; a_in_arr[11] = -1; a_in_arr[14] = 5; a_in_arr[15] = 6;
        exp_q.push_back(-5); exp_q.push_back(-3); exp_q.push_back(4); exp_q.push_back(32'sh7fffffff);
        run_a(1'b0, -1, cyc, bcyc, d0);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (a_out_arr[i] !== e) begin n_bad++; $display("FAIL negmax_out[%0d]: got %0d want %0d", i, a_out_arr[i], e); end
        end
    endtask

    task automatic test_k3_c2();
        int cyc, bcyc;
        logic signed [DW-1:0] e;
        for (int i = 0; i < 16; i++) begin
            b_in_arr[i]      = DW'(i);
            b_in_arr[16 + i] = -DW'(i);
        end
        exp_q.push_back(10); exp_q.push_back(11); exp_q.push_back(14); exp_q.push_back(15);
        exp_q.push_back(0);  exp_q.push_back(-1); exp_q.push_back(-4); exp_q.push_back(-5);
        run_b(1'b0, cyc, bcyc);
        n_cmp += 2;
        if (cyc != 72)  begin n_bad++; $display("FAIL k3_latency: got %0d want 72", cyc); end
        if (bcyc != 72) begin n_bad++; $display("FAIL k3_busy_cycles: got %0d want 72", bcyc); end
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (b_out_arr[i] !== e) begin n_bad++; $display("FAIL k3_out[%0d]: got %0d want %0d", i, b_out_arr[i], e); end
        end
    endtask

    task automatic test_reset_midrun();
        int cyc, bcyc;
        logic d0;
        logic signed [DW-1:0] e;
        for (int i = 0; i < 16; i++) a_in_arr[i] = $urandom();
        @(negedge clk);
        a_mode  = 1'b0;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp += 2;
        if (a_busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", a_busy); end
        if (a_done !== 1'b0) begin n_bad++; $display("FAIL midreset_done: got %b want 0", a_done); end
        for (int i = 0; i < 4; i++) exp_q.push_back('0);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (a_out_arr[i] !== e) begin n_bad++; $display("FAIL midreset_out[%0d]: got %0d want %0d", i, a_out_arr[i], e); end
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset mid-run: aborted at cycle 7");
        for (int oy = 0; oy < 2; oy++)
            for (int ox = 0; ox < 2; ox++) exp_q.push_back(model_a(oy, ox, 1'b1));
        run_a(1'b1, -1, cyc, bcyc, d0);
        n_cmp++;
        if (cyc != 16) begin n_bad++; $display("FAIL postreset_latency: got %0d want 16", cyc); end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (a_out_arr[i] !== e) begin n_bad++; $display("FAIL postreset_out[%0d]: got %0d want %0d", i, a_out_arr[i], e); end
        end
    endtask

    task automatic test_start_ignored();
        int cyc, bcyc;
        logic d0;
        logic signed [DW-1:0] e;
        for (int i = 0; i < 16; i++) a_in_arr[i] = $urandom();
        for (int oy = 0; oy < 2; oy++)
            for (int ox = 0; ox < 2; ox++) exp_q.push_back(model_a(oy, ox, 1'b0));
        run_a(1'b0, 5, cyc, bcyc, d0);
        n_cmp += 2;
        if (cyc != 16)  begin n_bad++; $display("FAIL ignored_start_latency: got %0d want 16", cyc); end
        if (bcyc != 16) begin n_bad++; $display("FAIL ignored_start_busy: got %0d want 16", bcyc); end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (a_out_arr[i] !== e) begin n_bad++; $display("FAIL ignored_start_out[%0d]: got %0d want %0d", i, a_out_arr[i], e); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc;
        logic d0;
        logic signed [DW-1:0] e;
        for (int i = 0; i < 16; i++) a_in_arr[i] = $urandom();
        for (int oy = 0; oy < 2; oy++)
            for (int ox = 0; ox < 2; ox++) exp_q.push_back(model_a(oy, ox, 1'b1));
        run_a(1'b1, -1, cyc, bcyc, d0);
        n_cmp += 3;
        if (d0 !== 1'b0) begin n_bad++; $display("FAIL restart_done_drop: got %b want 0", d0); end
        if (cyc != 16)   begin n_bad++; $display("FAIL restart_latency: got %0d want 16", cyc); end
        if (bcyc != 16)  begin n_bad++; $display("FAIL restart_busy: got %0d want 16", bcyc); end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (a_out_arr[i] !== e) begin n_bad++; $display("FAIL restart_out[%0d]: got %0d want %0d", i, a_out_arr[i], e); end
        end
    endtask

    initial begin
        rst     = 1'b1;
        a_start = 1'b0;
        a_mode  = 1'b0;
        b_start = 1'b0;
        b_mode  = 1'b0;
        for (int i = 0; i < 16; i++) a_in_arr[i] = '0;
        for (int i = 0; i < 32; i++) b_in_arr[i] = '0;
        test_reset();
        test_max();
        test_avg();
        test_neg_max();
        test_k3_c2();
        test_reset_midrun();
        test_start_ignored();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
